// File: rtl/dac_wave_player.sv
// Purpose : host-loaded I/Q sample buffer replayed to the DAC path at a programmable rate.
// Latency : first sample on data_i/data_q two cycles after play_start; then one sample per rate_div+1 cycles.
// Backpr. : none; pipe words are taken every cycle in LOAD, words beyond DEPTH are dropped and flag overflow.
//
// Ports:
//   okClk, reset           - sole clock, asynchronous active-high reset
//   load_start             - open a new load (clears write count and overflow)
//   ep_write, ep_dataout   - okPipeIn strobe and word ([11:0] = I, [27:16] = Q)
//   play_start, play_stop  - start / abort playback
//   loop_en, rate_div      - loop mode and sample divider, captured at play_start
//   data_i, data_q         - samples to the DAC path (midscale when not playing)
//   sample_valid, tx_en    - output carries buffer data / playback active
//   tx_done                - one-cycle pulse when a one-shot playback completes
//   wr_count, overflow     - samples loaded / sticky dropped-write flag
//
// Build option: define DAC_WAVE_OFFSET_BIN_EN to invert the MSB of every played
// sample (two's-complement host data -> offset-binary DAC code).
module dac_wave_player #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 12,
  parameter int DIV_W  = 8
) (
  input  logic              okClk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              ep_write,
  input  logic [31:0]       ep_dataout,
  input  logic              play_start,
  input  logic              play_stop,
  input  logic              loop_en,
  input  logic [DIV_W-1:0]  rate_div,
  output logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_q,
  output logic              sample_valid,
  output logic              tx_en,
  output logic              tx_done,
  output logic [ADDR_W:0]   wr_count,
  output logic              overflow
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [DATA_W-1:0] MIDSCALE  = {1'b1, {(DATA_W - 1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_DONE
  } state_t;

  state_t                state;
  logic [ADDR_W-1:0]     rd_ptr;
  logic [ADDR_W-1:0]     rd_ptr_nxt;
  logic [DIV_W-1:0]      div_cnt;
  logic [DIV_W-1:0]      rate_r;
  logic                  loop_r;
  logic                  draining;
  logic [2*DATA_W-1:0]   mem [DEPTH];
  logic [2*DATA_W-1:0]   rd_data;
  logic [DATA_W-1:0]     smp_i;
  logic [DATA_W-1:0]     smp_q;

  logic                  can_play;
  logic                  do_write;
  logic                  drop_write;
  logic                  at_last;
  logic                  advance;
  logic [ADDR_W-1:0]     wr_ptr;

  // Bits of the pipe word that carry no sample data.
  logic unused_ep_bits;
  assign unused_ep_bits = ^{ep_dataout[31:16+DATA_W], ep_dataout[15:DATA_W]};

  // The write pointer is the low part of the saturating sample count.
  assign wr_ptr = wr_count[ADDR_W-1:0];

  always_comb begin
    can_play   = play_start && !load_start && (wr_count != '0) &&
                 (state == S_IDLE || state == S_LOAD);
    do_write   = (state == S_LOAD) && ep_write && !load_start && (wr_count != DEPTH_CNT);
    drop_write = (state == S_LOAD) && ep_write && !load_start && (wr_count == DEPTH_CNT);
    at_last    = ({1'b0, rd_ptr} == (wr_count - (ADDR_W + 1)'(1)));
    advance    = (state == S_PLAY) && !draining && (div_cnt == '0);

    // rd_ptr is the address being fetched; it runs one cycle ahead of the
    // output register, so the RAM is addressed with its next value.
    rd_ptr_nxt = rd_ptr;
    if (can_play) begin
      rd_ptr_nxt = '0;
    end else if (advance && !load_start && !play_stop) begin
      if (!at_last) begin
        rd_ptr_nxt = rd_ptr + ADDR_W'(1);
      end else if (loop_r) begin
        rd_ptr_nxt = '0;
      end
    end
  end

  always_ff @(posedge okClk) begin
    if (do_write) begin
      mem[wr_ptr] <= {ep_dataout[16 +: DATA_W], ep_dataout[DATA_W-1:0]};
    end
    rd_data <= mem[rd_ptr_nxt];
  end

`ifdef DAC_WAVE_OFFSET_BIN_EN
  assign smp_i = rd_data[DATA_W-1:0] ^ MIDSCALE;
  assign smp_q = rd_data[2*DATA_W-1:DATA_W] ^ MIDSCALE;
`else
  assign smp_i = rd_data[DATA_W-1:0];
  assign smp_q = rd_data[2*DATA_W-1:DATA_W];
`endif

  always_ff @(posedge okClk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      rd_ptr       <= '0;
      div_cnt      <= '0;
      rate_r       <= '0;
      loop_r       <= 1'b0;
      draining     <= 1'b0;
      wr_count     <= '0;
      overflow     <= 1'b0;
      data_i       <= MIDSCALE;
      data_q       <= MIDSCALE;
      sample_valid <= 1'b0;
      tx_en        <= 1'b0;
      tx_done      <= 1'b0;
    end else begin
      rd_ptr       <= rd_ptr_nxt;
      data_i       <= MIDSCALE;
      data_q       <= MIDSCALE;
      sample_valid <= 1'b0;
      tx_en        <= 1'b0;
      tx_done      <= 1'b0;

      if (load_start) begin
        // A new load wins over everything, including a running playback.
        state    <= S_LOAD;
        wr_count <= '0;
        overflow <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_LOAD: begin
            if (do_write) begin
              wr_count <= wr_count + (ADDR_W + 1)'(1);
            end
            if (drop_write) begin
              overflow <= 1'b1;
            end
            if (can_play) begin
              state    <= S_PLAY;
              tx_en    <= 1'b1;
              rate_r   <= rate_div;
              loop_r   <= loop_en;
              div_cnt  <= rate_div;
              draining <= 1'b0;
            end
          end

          S_PLAY: begin
            if (play_stop) begin
              state <= S_IDLE;
            end else if (draining) begin
              // Last one-shot sample has had its full hold time.
              state    <= S_DONE;
              tx_done  <= 1'b1;
              draining <= 1'b0;
            end else begin
              tx_en        <= 1'b1;
              data_i       <= smp_i;
              data_q       <= smp_q;
              sample_valid <= 1'b1;
              if (div_cnt == '0) begin
                div_cnt <= rate_r;
                // Fetch of the final sample is over; its output copy still
                // needs one more cycle on the pins before DONE.
                if (at_last && !loop_r) begin
                  draining <= 1'b1;
                end
              end else begin
                div_cnt <= div_cnt - DIV_W'(1);
              end
            end
          end

          S_DONE: begin
            state <= S_IDLE;
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dac_wave_player.sv
// Purpose : self-checking bench for dac_wave_player with a sample scoreboard.
// Latency : expected samples carry their cycle number, so output timing is checked too.
// Backpr. : not applicable; the bench drives every input directly.
module tb_dac_wave_player;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 12;
  localparam int DIV_W  = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              okClk = 1'b0;
  logic              reset;
  logic              load_start;
  logic              ep_write;
  logic [31:0]       ep_dataout;
  logic              play_start;
  logic              play_stop;
  logic              loop_en;
  logic [DIV_W-1:0]  rate_div;
  logic [DATA_W-1:0] data_i;
  logic [DATA_W-1:0] data_q;
  logic              sample_valid;
  logic              tx_en;
  logic              tx_done;
  logic [ADDR_W:0]   wr_count;
  logic              overflow;

  always #5 okClk = ~okClk;

  dac_wave_player #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .okClk        (okClk),
    .reset        (reset),
    .load_start   (load_start),
    .ep_write     (ep_write),
    .ep_dataout   (ep_dataout),
    .play_start   (play_start),
    .play_stop    (play_stop),
    .loop_en      (loop_en),
    .rate_div     (rate_div),
    .data_i       (data_i),
    .data_q       (data_q),
    .sample_valid (sample_valid),
    .tx_en        (tx_en),
    .tx_done      (tx_done),
    .wr_count     (wr_count),
    .overflow     (overflow)
  );

  typedef struct {
    int          cyc;
    logic [11:0] i;
    logic [11:0] q;
  } exp_t;

  exp_t        sb[$];
  logic [11:0] mi [DEPTH];
  logic [11:0] mq [DEPTH];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [11:0] dac_code(input logic [11:0] s);
`ifdef DAC_WAVE_OFFSET_BIN_EN
    return s ^ 12'h800;
`else
    return s;
`endif
  endfunction

  // Advance one clock, then compare any valid output against the scoreboard.
  task automatic step();
    exp_t e;
    @(posedge okClk);
    #1;
    cyc++;
    if (sample_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(sample_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("smp_cycle", 32'(cyc), 32'(e.cyc));
        check("smp_i", 32'(data_i), 32'(e.i));
        check("smp_q", 32'(data_q), 32'(e.q));
      end
    end
  endtask

  // Expected output for ncyc cycles of playback of n samples held r+1 cycles.
  task automatic push_play(input int n, input int r, input int ncyc, input int c0);
    exp_t e;
    for (int t = 0; t < ncyc; t++) begin
      e.cyc = c0 + 2 + t;
      e.i   = dac_code(mi[(t / (r + 1)) % n]);
      e.q   = dac_code(mq[(t / (r + 1)) % n]);
      sb.push_back(e);
    end
  endtask

  function automatic logic [31:0] pipe_word(input int k);
    return {4'hA, mq[k], 4'h5, mi[k]};
  endfunction

  task automatic load(input int n);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int k = 0; k < n; k++) begin
      ep_write   = 1'b1;
      ep_dataout = pipe_word(k);
      step();
    end
    ep_write = 1'b0;
  endtask

  // One-shot playback of n samples; caller may leave a same-cycle write pending.
  task automatic play_oneshot(input int n, input int r);
    int len;
    len        = n * (r + 1);
    rate_div   = DIV_W'(r);
    loop_en    = 1'b0;
    play_start = 1'b1;
    push_play(n, r, len, cyc);
    for (int c = 1; c <= len + 3; c++) begin
      step();
      play_start = 1'b0;
      ep_write   = 1'b0;
      check("oneshot_tx_en", 32'(tx_en), 32'(c <= len + 1));
      check("oneshot_tx_done", 32'(tx_done), 32'(c == len + 2));
    end
    check("oneshot_sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    load_start = 1'b0;
    ep_write   = 1'b0;
    ep_dataout = '0;
    play_start = 1'b0;
    play_stop  = 1'b0;
    loop_en    = 1'b0;
    rate_div   = '0;

    // Reset state, then a lone play_start with an empty buffer.
    step();
    step();
    check("rst_data_i", 32'(data_i), 32'h800);
    check("rst_data_q", 32'(data_q), 32'h800);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_tx_en", 32'(tx_en), 32'd0);
    check("rst_tx_done", 32'(tx_done), 32'd0);
    check("rst_wr_count", 32'(wr_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset      = 1'b0;
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("empty_play_tx_en", 32'(tx_en), 32'd0);
    end

    // Four-sample buffer, one-shot at two rates.
    for (int k = 0; k < 4; k++) begin
      mi[k] = 12'(k + 1);
      mq[k] = 12'(16 + k);
    end
    load(4);
    check("load4_wr_count", 32'(wr_count), 32'd4);
    play_oneshot(4, 0);
    play_oneshot(4, 3);

    // Loop at rate_div = 2, stopped after six sample periods.
    rate_div   = 8'd2;
    loop_en    = 1'b1;
    play_start = 1'b1;
    push_play(4, 2, 18, cyc);
    for (int c = 1; c <= 19; c++) begin
      step();
      play_start = 1'b0;
      check("loop_tx_en", 32'(tx_en), 32'd1);
    end
    play_stop = 1'b1;
    step();
    play_stop = 1'b0;
    check("stop_data_i", 32'(data_i), 32'h800);
    check("stop_data_q", 32'(data_q), 32'h800);
    check("stop_tx_en", 32'(tx_en), 32'd0);
    for (int c = 0; c < 3; c++) begin
      check("stop_tx_done", 32'(tx_done), 32'd0);
      step();
    end
    check("loop_sb_empty", 32'(sb.size()), 32'd0);

    // load_start together with play_start while playing: new load wins.
    rate_div   = 8'd0;
    loop_en    = 1'b1;
    play_start = 1'b1;
    push_play(4, 0, 4, cyc);
    for (int c = 1; c <= 5; c++) begin
      step();
      play_start = 1'b0;
    end
    load_start = 1'b1;
    play_start = 1'b1;
    step();
    load_start = 1'b0;
    play_start = 1'b0;
    check("abort_tx_en", 32'(tx_en), 32'd0);
    check("abort_wr_count", 32'(wr_count), 32'd0);
    check("abort_tx_done", 32'(tx_done), 32'd0);
    check("abort_valid", 32'(sample_valid), 32'd0);
    ep_write   = 1'b1;
    ep_dataout = pipe_word(0);
    step();
    ep_write = 1'b0;
    check("abort_in_load", 32'(wr_count), 32'd1);
    check("abort_sb_empty", 32'(sb.size()), 32'd0);

    // Overfill the buffer.
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int k = 0; k < DEPTH + 3; k++) begin
      ep_write   = 1'b1;
      ep_dataout = 32'(k);
      step();
    end
    ep_write = 1'b0;
    check("ovf_wr_count", 32'(wr_count), 32'(DEPTH));
    check("ovf_flag", 32'(overflow), 32'd1);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    check("ovf_clr_count", 32'(wr_count), 32'd0);
    check("ovf_clr_flag", 32'(overflow), 32'd0);

    // Edge codes; the fifth word is written in the play_start cycle.
    mi[0] = 12'h000; mq[0] = 12'hFFF;
    mi[1] = 12'hFFF; mq[1] = 12'h000;
    mi[2] = 12'h7FF; mq[2] = 12'h123;
    mi[3] = 12'h800; mq[3] = 12'hABC;
    mi[4] = 12'h5A5; mq[4] = 12'h0F0;
    for (int k = 0; k < 4; k++) begin
      ep_write   = 1'b1;
      ep_dataout = pipe_word(k);
      step();
    end
    ep_write   = 1'b1;
    ep_dataout = pipe_word(4);
    play_oneshot(5, 1);
    check("codes_wr_count", 32'(wr_count), 32'd5);

    // Reset in the middle of a looped playback.
    rate_div   = 8'd0;
    loop_en    = 1'b1;
    play_start = 1'b1;
    push_play(5, 0, 2, cyc);
    for (int c = 1; c <= 3; c++) begin
      step();
      play_start = 1'b0;
    end
    reset = 1'b1;
    step();
    check("midrst_data_i", 32'(data_i), 32'h800);
    check("midrst_data_q", 32'(data_q), 32'h800);
    check("midrst_tx_en", 32'(tx_en), 32'd0);
    check("midrst_wr_count", 32'(wr_count), 32'd0);
    check("midrst_valid", 32'(sample_valid), 32'd0);
    reset      = 1'b0;
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("midrst_play_ignored", 32'(tx_en), 32'd0);
    end
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
